// File: rtl/uart_tx_if.sv
// Host-side word interface of the UART transmitter: request/data in, busy/done back.
// The host (or TX FIFO) takes the master modport, the transmitter takes slave.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] din;
  logic       tx_busy;
  logic       tx_done_tick;

  modport master (
    output tx_start,
    output din,
    input  tx_busy,
    input  tx_done_tick
  );

  modport slave (
    input  tx_start,
    input  din,
    output tx_busy,
    output tx_done_tick
  );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start, DBIT data bits LSB first, optional even parity, stop.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  uart_tx_if.slave   host,
  output logic       tx
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [4:0] TICK_LAST = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

  logic [2:0] state_reg, state_next;
  logic [4:0] s_reg, s_next;
  logic [2:0] n_reg, n_next;
  logic [7:0] b_reg, b_next;
  logic       tx_reg, tx_next;
  logic       done;
  logic [7:0] din_used;

  // Bits above DBIT are forced to zero so they never reach the line or the parity.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_din_mask
      if (gi < DBIT) begin : g_keep
        assign din_used[gi] = host.din[gi];
      end else begin : g_drop
        assign din_used[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  // The shift register is consumed by the time the parity bit goes out,
  // so the parity is captured alongside the word.
  logic par_reg, par_next;
`endif

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    done       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (host.tx_start) begin
          b_next     = din_used;
          s_next     = 5'd0;
          state_next = ST_START;
`ifdef UART_TX_PARITY_EN
          par_next   = ^din_used;
`endif
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_reg == TICK_LAST) begin
            s_next     = 5'd0;
            n_next     = 3'd0;
            state_next = ST_DATA;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_reg == TICK_LAST) begin
            s_next = 5'd0;
            b_next = b_reg >> 1;
            if (n_reg == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_next = ST_PARITY;
`else
              state_next = ST_STOP;
`endif
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_reg == TICK_LAST) begin
            s_next     = 5'd0;
            state_next = ST_STOP;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_reg == STOP_LAST) begin
            state_next = ST_IDLE;
            done       = 1'b1;
          end else begin
            s_next = s_reg + 5'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The line level follows the state being entered so tx stays glitch-free and registered.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = par_next;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      s_reg     <= 5'd0;
      n_reg     <= 3'd0;
      b_reg     <= 8'd0;
      tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
`ifdef UART_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  assign tx                = tx_reg;
  assign host.tx_busy      = (state_reg != ST_IDLE);
  assign host.tx_done_tick = done;

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter: serialises one parallel data word per request into a standard asynchronous frame (start bit, DBIT data bits LSB first, optional parity bit, stop bit) on a single output line. It pairs with the UART receiver and shares its baud-rate generator. Every bit period is timed by the same 16x oversampling `s_tick` strobe. The block sits between a host-side word interface (or TX FIFO) and the `tx` pad.

## Interface
- `DBIT`, 8: number of data bits per frame, 5..8; `din[DBIT-1:0]` is sent, upper bits ignored.
- `SB_TICK`, 16: stop-bit length in `s_tick` periods; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk` rising edge; 0 = reset).
- `s_tick`  in  1  one-`clk` enable strobe at 16x baud rate.
- `tx_start`  in  1  request to send `din`; honoured only in idle.
- `din`  in  8  word to transmit; captured on the accepted `tx_start` cycle.
- `tx_done_tick`  out  1  one-`clk` pulse when the stop bit completes.
- `tx_busy`  out  1  high from the cycle after acceptance until the return to idle.
- `tx`  out  1  serial line; registered; idles high.

## Operation
- Registered state: `state` (idle, start, data, [parity], stop), tick counter `s` (0..31), bit counter `n` (0..7), shift register `b` (8b), `tx_reg`.
- idle: `tx`=1. If `tx_start`=1: `b`<=`din`, `s`<=0, state<=start. `s_tick` is not required to accept.
- start: `tx`=0. On each `s_tick`: if `s`==15 then `s`<=0, `n`<=0, state<=data; else `s`<=`s`+1.
- data: `tx`=`b[0]`. On each `s_tick` with `s`==15: `s`<=0, `b`<=`b`>>1; if `n`==DBIT-1, go to the next state (parity if compiled in, else stop); else `n`<=`n`+1. Other `s_tick`: `s`<=`s`+1.
- parity (macro only): `tx`=parity bit. After 16 ticks, state<=stop.
- stop: `tx`=1. On `s_tick` with `s`==SB_TICK-1: state<=idle, `tx_done_tick`=1 for that cycle. Otherwise `s`<=`s`+1.
- `tx_start` outside idle is ignored; the request is not queued. `din` changes after acceptance do not affect the frame.
- `tx_busy` = (state != idle).
- Counter widths must hold SB_TICK-1 without wrap. SB_TICK > 32 is unsupported.

## Timing
- Reset (`reset`=0 at a `clk` edge): state=idle, `s`=`n`=`b`=0, `tx`=1, `tx_busy`=0, `tx_done_tick`=0. Reset takes priority over all inputs.
- Reset mid-frame: `tx` returns high at the next edge. No `tx_done_tick` is issued. The frame is truncated.
- Acceptance latency: `tx_start` sampled high in idle at edge k gives `tx`=0 and `tx_busy`=1 after edge k.
- Bit duration: exactly 16 `s_tick` strobes per start, data and parity bit. Stop lasts SB_TICK strobes.
- Frame length: (1+DBIT+P)*16 + SB_TICK strobes, where P=1 with parity, else 0.
- `tx_done_tick` is combinational from state: it is high during the cycle of the final stop `s_tick`. Idle follows after that edge.
- Back-to-back: `tx_start` may be asserted in the first idle cycle after `tx_done_tick`. The line then shows no extra idle beyond one `clk`.
- `tx_start` coincident with `tx_done_tick` is ignored, because the state is still stop.

## Configuration
- `UART_TX_PARITY_EN` defined: a parity state is inserted after data. The parity bit is even parity: XOR of the DBIT data bits. Frame grows by 16 ticks.
- Not defined: no parity state and no parity logic. The frame is start, data, stop.
- The receiver must be built with the matching setting.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `tx_start`=1 -> `tx`=1, `tx_busy`=0, `tx_done_tick`=0 throughout.
- Single frame: DBIT=8, SB_TICK=16, `s_tick` every 4th `clk`, `din`=0xA5 -> `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 64 clk; one `tx_done_tick` 640 clk after acceptance.
- Busy rejection: pulse `tx_start` with `din`=0x3C mid-frame of 0xA5 -> 0xA5 sent intact; no second frame; exactly one `tx_done_tick`.
- Back-to-back: assert `tx_start` with 0x00 in the cycle after `tx_done_tick` -> start bit begins next edge; 8 zero data bits follow.
- Reset mid-data: assert `reset`=0 during bit 3 -> `tx`=1 next edge; no `tx_done_tick`; a new `tx_start` then sends a full frame.
- With `UART_TX_PARITY_EN`, DBIT=7, `din`=0x07 -> data bits 1,1,1,0,0,0,0, then parity 1, then stop; frame = 9*16+16 ticks.
